// File: rtl/axi_to_wb_pkg.sv
// Shared definitions for the AXI-Lite <-> Wishbone bridges: FSM encoding,
// byte-select pattern and the user-area address / error-data defaults.
package axi_to_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WB_WR   = 2'd1,
        ST_WB_RD   = 2'd2,
        ST_RD_RESP = 2'd3
    } state_e;

    localparam logic [3:0]  WB_SEL_ALL           = 4'b1111;
    localparam logic [31:0] WB_BASE_ADDR_DEFAULT = 32'h3000_0000;
    localparam logic [31:0] WB_ERR_DATA_DEFAULT  = 32'hDEAD_BEEF;

endpackage

// File: rtl/axi_to_wb.sv
// AXI-Lite slave (AW/W/AR/R, no B) to Wishbone master bridge issuing single
// 32-bit cycles into the user area, with an ack timeout that forces termination.
module axi_to_wb
    import axi_to_wb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = WB_BASE_ADDR_DEFAULT,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = WB_ERR_DATA_DEFAULT
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [31:0]       rdata,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [31:0]       wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic              wbm_ack_i,
    input  logic [31:0]       wbm_dat_i,
    output logic              err_o
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              ready_en_q, ready_en_d;
    logic              aw_hold_q, aw_hold_d;
    logic              w_hold_q, w_hold_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [31:0]       adr_q, adr_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic idle, aw_hs, w_hs, ar_hs;

    // Readies stay low for the first cycle out of reset so every output is 0 in reset.
    assign idle    = ready_en_q && (state_q == ST_IDLE);
    assign awready = idle && !aw_hold_q;
    assign wready  = idle && !w_hold_q;
    assign arready = idle && !aw_hold_q && !w_hold_q && !awvalid && !wvalid;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    always_comb begin
        state_d    = state_q;
        ready_en_d = 1'b1;
        aw_hold_d  = aw_hold_q;
        w_hold_d   = w_hold_q;
        aw_addr_d  = aw_addr_q;
        wdat_d     = wdat_q;
        adr_d      = adr_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        cnt_d      = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    aw_hold_d = 1'b1;
                    aw_addr_d = awaddr;
                end
                if (w_hs) begin
                    w_hold_d = 1'b1;
                    wdat_d   = wdata;
                end
                if (aw_hold_d && w_hold_d) begin
                    state_d = ST_WB_WR;
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    adr_d   = BASE_ADDR | 32'(aw_addr_d);
                    cnt_d   = '0;
                end else if (ar_hs) begin
                    state_d = ST_WB_RD;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = BASE_ADDR | 32'(araddr);
                    cnt_d   = '0;
                end
            end
            ST_WB_WR: begin
                if (wbm_ack_i || cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    aw_hold_d = 1'b0;
                    w_hold_d  = 1'b0;
                    err_d     = !wbm_ack_i;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WB_RD: begin
                if (wbm_ack_i || cnt_q == CNT_LAST) begin
                    state_d  = ST_RD_RESP;
                    cyc_d    = 1'b0;
                    rvalid_d = 1'b1;
                    rdata_d  = wbm_ack_i ? wbm_dat_i : ERR_DATA;
                    err_d    = !wbm_ack_i;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RD_RESP: begin
                if (rready) begin
                    state_d  = ST_IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            ready_en_q <= 1'b0;
            aw_hold_q  <= 1'b0;
            w_hold_q   <= 1'b0;
            aw_addr_q  <= '0;
            wdat_q     <= '0;
            adr_q      <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= ready_en_d;
            aw_hold_q  <= aw_hold_d;
            w_hold_q   <= w_hold_d;
            aw_addr_q  <= aw_addr_d;
            wdat_q     <= wdat_d;
            adr_q      <= adr_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = cyc_q ? WB_SEL_ALL : '0;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = wdat_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign err_o     = err_q;

endmodule
